data_memory_pipe: RTL and testbench
===================================

Name: data_memory_pipe

Overview:
Parametrised successor to the 256x16 single-port DataMemory.
- Configurable width, depth and read latency; per-byte write enables; valid/ready request handshake; valid-tagged read response.
- After reset, a hardware clear sequence zeroes every word before accepting requests.
- Sits between the CPU load/store stage and on-chip data storage.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, write-enable granularity in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words (default 256).
- RD_LAT, 1, read latency in cycles; legal range 1..3. A value of 1 matches the legacy DataMemory q timing.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_wren  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_data  in  DATA_W  write data.
- req_be  in  DATA_W/BYTE_W  byte write enables; ignored for reads.
- req_inj_err  in  1  parity-error injection on write; used only with DATA_MEM_PARITY_EN.
- rsp_valid  out  1  one-cycle pulse per accepted read.
- rsp_data  out  DATA_W  read data, qualified by rsp_valid.
- rsp_err  out  1  parity error on this response, qualified by rsp_valid.
- init_done  out  1  high once the clear sequence has completed.

Behaviour:
- FSM states: ST_INIT, ST_RUN.
- Reset (sampled at an edge): state=ST_INIT, clear counter=0, req_ready=0, init_done=0, rsp_valid=0, rsp_data=0, rsp_err=0. All in-flight reads are discarded.
- ST_INIT:
  - Each cycle writes 0 (and correct parity) to word[counter], then counter increments.
  - On the edge that writes word DEPTH-1: go to ST_RUN, init_done=1.
  - Takes exactly DEPTH cycles. req_valid is ignored and produces no response.
- ST_RUN:
  - req_ready=1 every cycle; there is no response backpressure.
  - Write: at the accepting edge, each byte i with req_be[i]=1 is updated; bytes with req_be[i]=0 keep their old value. be=0 is a legal no-op. A write produces no response.
  - Read accepted at edge t: rsp_valid=1 and rsp_data=word[req_addr] during the cycle after edge t+RD_LAT-1. rsp_valid is 0 otherwise.
  - Back-to-back reads give one response per cycle, in request order.
  - Read the cycle after a write to the same address returns the new data, because the array is updated at the write edge.
  - Address wrap: ADDR_W covers the full depth, so no out-of-range case exists.
- Reset asserted in ST_RUN or ST_INIT: pipeline flushes, no stale rsp_valid appears, and the clear sequence restarts from word 0.

Optional Feature:
Macro DATA_MEM_PARITY_EN.
- With it:
  - One even-parity bit is stored per byte.
  - On a write with req_inj_err=1, the stored parity of each enabled byte is inverted.
  - On read, rsp_err=1 if any byte parity mismatches.
- Without it: no parity storage, rsp_err is tied to 0, and req_inj_err is ignored.
- The port list is identical in both builds.

Decomposition:
- Package data_mem_pkg holds:
  - the state enum (ST_INIT, ST_RUN);
  - default DATA_W, BYTE_W and ADDR_W constants;
  - the byte-parity function.
- One sub-module, data_mem_rd_pipe: RD_LAT-deep delay line for valid, data and err, with synchronous flush on reset.

Test Plan:
1. Reset pulse, then idle -> init_done rises exactly 256 cycles after reset deasserts. A read of addr 200 then returns 0x0000.
2. Write 0x000A to addr 76 (be=2'b11), then read 76 -> rsp_data=0x000A, rsp_valid 1 cycle after acceptance (RD_LAT=1). Write 0x000B to 76, read -> 0x000B.
3. With 76=0x000A, write 0xBEEF with be=2'b10, then read -> 0xBE0A. Write with be=2'b00, then read -> still 0xBE0A.
4. RD_LAT=3: reads of addr 0..3 on consecutive cycles (preloaded 0x1111..0x4444) -> four consecutive rsp_valid pulses in order, the first 3 cycles after the first acceptance.
5. Reset asserted while 2 reads are in flight -> no rsp_valid afterwards; req_ready=0 for 256 cycles; addr 76 reads 0x0000 after init.
6. With DATA_MEM_PARITY_EN: write 0x1234 to addr 5 with req_inj_err=1, then read -> rsp_data=0x1234, rsp_err=1. Rewrite with req_inj_err=0, then read -> rsp_err=0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data_memory_pipe block:
//   - state_e       : controller states (clear sequence, normal operation)
//   - *_DEF         : default word width, byte width and address width
//   - byte_parity() : even-parity bit of one byte (zero-extended to MAX_BYTE_W)
// ----------------------------------------------------------------------------
package data_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int BYTE_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  // Widest byte lane byte_parity() accepts; callers zero-extend narrower lanes.
  localparam int MAX_BYTE_W = 64;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Even parity: the stored bit makes the total count of ones even, so it is
  // simply the XOR of the data bits. Zero padding does not change the result.
  function automatic logic byte_parity(input logic [MAX_BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/data_mem_rd_pipe.sv
// ----------------------------------------------------------------------------
// data_mem_rd_pipe
// RD_LAT-deep delay line carrying the read response (valid, data, err).
// Stage 0 captures the combinational array read at the accepting edge, so the
// response appears RD_LAT-1 edges after acceptance.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high flush of every stage
//   in_valid   in   read accepted this cycle
//   in_data    in   word read from the array
//   in_err     in   parity error for that word
//   out_valid  out  one-cycle response pulse
//   out_data   out  response data (qualified by out_valid)
//   out_err    out  response parity error (qualified by out_valid)
// ----------------------------------------------------------------------------
module data_mem_rd_pipe #(
  parameter int W      = 16,
  parameter int RD_LAT = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_err,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] err_q;
  logic [W-1:0]      data_q [RD_LAT];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_valid & in_err;
      // Data only moves into the pipe with a real read; idle cycles hold it.
      if (in_valid) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_err   = err_q[RD_LAT-1];
  assign out_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/data_memory_pipe.sv
// ----------------------------------------------------------------------------
// data_memory_pipe
// Single-port data memory with per-byte write enables, a valid/ready request
// port and a valid-tagged read response delayed by RD_LAT cycles. After reset
// the controller zeroes every word (one per cycle, DEPTH cycles) before it
// accepts requests.
//
// Handshake: a request transfers at a rising edge where req_valid && req_ready.
// req_ready is high in every ST_RUN cycle; responses cannot be back-pressured.
//
// Optional build macro DATA_MEM_PARITY_EN: stores one even-parity bit per byte,
// req_inj_err inverts the stored parity of written bytes, and rsp_err flags a
// mismatch on read. Without it rsp_err is 0 and req_inj_err is ignored.
//
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   req_valid / req_ready   request handshake
//   req_wren                1 = write, 0 = read
//   req_addr, req_data      word address and write data
//   req_be                  byte write enables (writes only)
//   req_inj_err             parity-error injection on write
//   rsp_valid               one-cycle pulse per accepted read
//   rsp_data, rsp_err       response data and parity error
//   init_done               high once the clear sequence has finished
//                           (mirrors the controller state: 1 = ST_RUN)
// ----------------------------------------------------------------------------
module data_memory_pipe
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wren,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_data,
  input  logic [DATA_W/BYTE_W-1:0] req_be,
  input  logic                     req_inj_err,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     init_done
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Single write port shared by the clear sequence and CPU writes.
  logic              wr_en;
  logic [NB-1:0]     wr_be;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_fire;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    wr_en     = 1'b0;
    wr_be     = '0;
    wr_addr   = req_addr;
    wr_data   = req_data;
    rd_fire   = 1'b0;
    case (state_q)
      ST_INIT: begin
        wr_en   = ~reset;
        wr_be   = '1;
        wr_addr = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        req_ready = 1'b1;
        if (req_valid && !reset) begin
          if (req_wren) begin
            wr_en = 1'b1;
            wr_be = req_be;
          end else begin
            rd_fire = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign init_done = (state_q == ST_RUN);

  // Array is written at the accepting edge, so a read issued the next cycle
  // already sees the new bytes.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rd_data = mem_q[req_addr];

`ifdef DATA_MEM_PARITY_EN
  logic [NB-1:0]         par_q [DEPTH];
  logic [NB-1:0]         wr_par;
  logic [NB-1:0]         rd_par;
  logic [MAX_BYTE_W-1:0] wr_byte_ext;
  logic [MAX_BYTE_W-1:0] rd_byte_ext;
  logic                  wr_inj;

  // The clear sequence never injects errors.
  assign wr_inj = (state_q == ST_RUN) && req_inj_err;

  always_comb begin
    wr_par      = '0;
    rd_par      = '0;
    wr_byte_ext = '0;
    rd_byte_ext = '0;
    for (int i = 0; i < NB; i++) begin
      wr_byte_ext                = '0;
      wr_byte_ext[BYTE_W-1:0]    = wr_data[i*BYTE_W +: BYTE_W];
      wr_par[i]                  = byte_parity(wr_byte_ext) ^ wr_inj;
      rd_byte_ext                = '0;
      rd_byte_ext[BYTE_W-1:0]    = rd_data[i*BYTE_W +: BYTE_W];
      rd_par[i]                  = byte_parity(rd_byte_ext);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          par_q[wr_addr][i] <= wr_par[i];
        end
      end
    end
  end

  assign rd_err = |(rd_par ^ par_q[req_addr]);
`else
  logic unused_inj_err;
  assign unused_inj_err = req_inj_err;
  assign rd_err         = 1'b0;
`endif

  data_mem_rd_pipe #(
    .W      (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (rd_fire),
    .in_data   (rd_data),
    .in_err    (rd_err),
    .out_valid (rsp_valid),
    .out_data  (rsp_data),
    .out_err   (rsp_err)
  );

endmodule

// File: tb/tb_data_memory_pipe.sv
// ----------------------------------------------------------------------------
// tb_data_memory_pipe
// Two instances share one request stream: u_dut_lat1 (RD_LAT=1) and
// u_dut_lat3 (RD_LAT=3). A word-array model with per-byte "parity corrupted"
// flags predicts each read; predictions are queued per instance with the
// cycle they are due and checked by a negedge monitor. Scenario tasks add
// direct constant checks for the documented cases.
// ----------------------------------------------------------------------------
module tb_data_memory_pipe;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int NB     = 2;
  localparam int DEPTH  = 256;
`ifdef DATA_MEM_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset       = 1'b1;
  logic              req_valid   = 1'b0;
  logic              req_wren    = 1'b0;
  logic              req_inj_err = 1'b0;
  logic [ADDR_W-1:0] req_addr    = '0;
  logic [DATA_W-1:0] req_data    = '0;
  logic [NB-1:0]     req_be      = '0;

  logic [1:0]             req_ready_w;
  logic [1:0]             rsp_valid_w;
  logic [1:0]             rsp_err_w;
  logic [1:0]             init_done_w;
  logic [1:0][DATA_W-1:0] rsp_data_w;

  data_memory_pipe #(.DATA_W(16), .BYTE_W(8), .ADDR_W(8), .RD_LAT(1)) u_dut_lat1 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_w[0]),
    .req_wren(req_wren), .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .req_inj_err(req_inj_err), .rsp_valid(rsp_valid_w[0]), .rsp_data(rsp_data_w[0]),
    .rsp_err(rsp_err_w[0]), .init_done(init_done_w[0])
  );

  data_memory_pipe #(.DATA_W(16), .BYTE_W(8), .ADDR_W(8), .RD_LAT(3)) u_dut_lat3 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_w[1]),
    .req_wren(req_wren), .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .req_inj_err(req_inj_err), .rsp_valid(rsp_valid_w[1]), .rsp_data(rsp_data_w[1]),
    .rsp_err(rsp_err_w[1]), .init_done(init_done_w[1])
  );

  int check_cnt = 0;
  int fail_cnt  = 0;
  int cyc       = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- reference model + scoreboard ----------------
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [NB-1:0]     model_bad [DEPTH];
  // entry = {due_cycle[31:0], err, data[15:0]}
  logic [48:0]       exp_q [2][$];
  int                lat [2] = '{1, 3};

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_bad[i] = '0;
    end
    exp_q[0].delete();
    exp_q[1].delete();
  endtask

  always @(negedge clock) begin
    logic [48:0] e;
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid_w[d] === 1'b1) begin
        check_cnt++;
        if (exp_q[d].size() == 0) begin
          fail_cnt++;
          $display("FAIL rsp_spurious lat%0d: rsp_valid=1 data=%h at cycle %0d, required no response",
                   lat[d], rsp_data_w[d], cyc);
        end else begin
          e = exp_q[d].pop_front();
          if (e[48:17] != 32'(cyc) || rsp_data_w[d] !== e[15:0] || rsp_err_w[d] !== e[16]) begin
            fail_cnt++;
            $display("FAIL rsp_match lat%0d: got data=%h err=%b at cycle %0d, required data=%h err=%b at cycle %0d",
                     lat[d], rsp_data_w[d], rsp_err_w[d], cyc, e[15:0], e[16], e[48:17]);
          end
        end
      end else if (exp_q[d].size() != 0 && exp_q[d][0][48:17] <= 32'(cyc)) begin
        e = exp_q[d].pop_front();
        check_cnt++;
        fail_cnt++;
        $display("FAIL rsp_missing lat%0d: rsp_valid=%b at cycle %0d, required data=%h at cycle %0d",
                 lat[d], rsp_valid_w[d], cyc, e[15:0], e[48:17]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_req(input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] dat, input logic [NB-1:0] be,
                        input logic inj);
    check_cnt++;
    if (req_ready_w !== 2'b11) begin
      fail_cnt++;
      $display("FAIL req_ready: got %b, required 11 before request", req_ready_w);
    end
    req_valid = 1'b1; req_wren = wr; req_addr = a; req_data = dat;
    req_be = be; req_inj_err = inj;
    @(posedge clock);
    #1;
    if (!wr) begin
      for (int d = 0; d < 2; d++)
        exp_q[d].push_back({32'(cyc + lat[d] - 1), PAR_EN & (|model_bad[a]), model_mem[a]});
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          model_mem[a][i*8 +: 8] = dat[i*8 +: 8];
          model_bad[a][i]        = inj;
        end
      end
    end
    req_valid = 1'b0; req_wren = 1'b0; req_inj_err = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10 && (exp_q[0].size() + exp_q[1].size()) != 0; i++) begin
      @(posedge clock);
      #1;
    end
    check_cnt++;
    if ((exp_q[0].size() + exp_q[1].size()) != 0) begin
      fail_cnt++;
      $display("FAIL drain: %0d/%0d responses outstanding, required 0", exp_q[0].size(), exp_q[1].size());
      exp_q[0].delete();
      exp_q[1].delete();
    end
  endtask

  // Reset, then count cycles until init_done; requests must be refused meanwhile.
  task automatic do_reset_init();
    int   n;
    logic ready_bad;
    logic valid_bad;
    n = 0; ready_bad = 1'b0; valid_bad = 1'b0;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b0;
    req_valid = 1'b1;   // must be ignored during the clear sequence
    req_addr  = 8'd33;
    while (n < 300 && init_done_w !== 2'b11) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (init_done_w !== 2'b11) begin
        if (req_ready_w !== 2'b00) ready_bad = 1'b1;
        if (rsp_valid_w !== 2'b00) valid_bad = 1'b1;
      end
    end
    req_valid = 1'b0;
    check_cnt++;
    if (n != 256) begin
      fail_cnt++;
      $display("FAIL init_cycles: init_done after %0d cycles (state %b), required 256", n, init_done_w);
    end
    check_cnt++;
    if (ready_bad) begin
      fail_cnt++;
      $display("FAIL init_ready: req_ready seen high during clear, required 00");
    end
    check_cnt++;
    if (valid_bad) begin
      fail_cnt++;
      $display("FAIL init_rsp: rsp_valid seen high during clear, required 00");
    end
    @(posedge clock);
    #1;
  endtask

  // Direct check of the RD_LAT=1 response in the cycle after acceptance.
  task automatic expect_lat1(input string name, input logic [DATA_W-1:0] dat, input logic err);
    @(negedge clock);
    check_cnt++;
    if (rsp_valid_w[0] !== 1'b1 || rsp_data_w[0] !== dat || rsp_err_w[0] !== err) begin
      fail_cnt++;
      $display("FAIL %s: got valid=%b data=%h err=%b, required valid=1 data=%h err=%b",
               name, rsp_valid_w[0], rsp_data_w[0], rsp_err_w[0], dat, err);
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(posedge clock);
    #1;
    check_cnt++;
    if (rsp_valid_w !== 2'b00 || rsp_err_w !== 2'b00 || init_done_w !== 2'b00 ||
        req_ready_w !== 2'b00 || rsp_data_w !== 32'h0) begin
      fail_cnt++;
      $display("FAIL reset_state: valid=%b err=%b done=%b ready=%b data=%h, required all zero",
               rsp_valid_w, rsp_err_w, init_done_w, req_ready_w, rsp_data_w);
    end
    do_reset_init();
    do_req(1'b0, 8'd200, '0, '0, 1'b0);
    expect_lat1("read_after_init", 16'h0000, 1'b0);
    wait_drain();
  endtask

  task automatic test_write_read();
    do_req(1'b1, 8'd76, 16'h000A, 2'b11, 1'b0);
    do_req(1'b0, 8'd76, '0, '0, 1'b0);
    expect_lat1("write_read_a", 16'h000A, 1'b0);
    check_cnt++;
    if (rsp_valid_w[0] !== 1'b0) begin
      fail_cnt++;
      $display("FAIL rsp_pulse: rsp_valid=%b the cycle after a response, required 0", rsp_valid_w[0]);
    end
    do_req(1'b1, 8'd76, 16'h000B, 2'b11, 1'b0);
    do_req(1'b0, 8'd76, '0, '0, 1'b0);
    expect_lat1("write_read_b", 16'h000B, 1'b0);
    wait_drain();
  endtask

  task automatic test_byte_enable();
    do_req(1'b1, 8'd76, 16'h000A, 2'b11, 1'b0);
    do_req(1'b1, 8'd76, 16'hBEEF, 2'b10, 1'b0);
    do_req(1'b0, 8'd76, '0, '0, 1'b0);
    expect_lat1("be_upper", 16'hBE0A, 1'b0);
    do_req(1'b1, 8'd76, 16'h1234, 2'b00, 1'b0);
    do_req(1'b0, 8'd76, '0, '0, 1'b0);
    expect_lat1("be_none", 16'hBE0A, 1'b0);
    do_req(1'b1, 8'd76, 16'h5566, 2'b01, 1'b0);
    do_req(1'b0, 8'd76, '0, '0, 1'b0);
    expect_lat1("be_lower", 16'hBE66, 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] pat;
    pat = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 8'(i), pat, 2'b11, 1'b0);
      pat = pat + 16'h1111;
    end
    for (int i = 0; i < 4; i++) do_req(1'b0, 8'(i), '0, '0, 1'b0);
    // Last read accepted this cycle: lat1 returns it now, lat3 returns read 1.
    @(negedge clock);
    check_cnt++;
    if (rsp_valid_w !== 2'b11 || rsp_data_w[0] !== 16'h4444 || rsp_data_w[1] !== 16'h2222) begin
      fail_cnt++;
      $display("FAIL b2b_overlap: valid=%b lat1=%h lat3=%h, required 11 4444 2222",
               rsp_valid_w, rsp_data_w[0], rsp_data_w[1]);
    end
    @(posedge clock);
    #1;
    wait_drain();
  endtask

  task automatic test_reset_inflight();
    do_req(1'b1, 8'd76, 16'h000A, 2'b11, 1'b0);
    do_req(1'b0, 8'd10, '0, '0, 1'b0);
    do_req(1'b0, 8'd76, '0, '0, 1'b0);
    do_reset_init();
    do_req(1'b0, 8'd76, '0, '0, 1'b0);
    expect_lat1("reset_cleared", 16'h0000, 1'b0);
    wait_drain();
  endtask

  task automatic test_parity();
    do_req(1'b1, 8'd5, 16'h1234, 2'b11, 1'b1);
    do_req(1'b0, 8'd5, '0, '0, 1'b0);
    expect_lat1("parity_inject", 16'h1234, PAR_EN);
    do_req(1'b1, 8'd5, 16'h1234, 2'b11, 1'b0);
    do_req(1'b0, 8'd5, '0, '0, 1'b0);
    expect_lat1("parity_clean", 16'h1234, 1'b0);
    do_req(1'b1, 8'd5, 16'h0077, 2'b01, 1'b1);
    do_req(1'b0, 8'd5, '0, '0, 1'b0);
    expect_lat1("parity_byte", 16'h1277, PAR_EN);
    wait_drain();
  endtask

  task automatic test_random();
    int op;
    logic [ADDR_W-1:0] a;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 4);
      a  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      if (op == 0) begin
        @(posedge clock);
        #1;
      end else if (op == 1 || op == 2) begin
        do_req(1'b1, a, 16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)),
               $urandom_range(0, 3) == 0);
      end else begin
        do_req(1'b0, a, '0, '0, 1'b0);
      end
    end
    wait_drain();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_reset_inflight();
    test_parity();
    test_random();
    repeat (5) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
